// File: rtl/normalize_shifter_pipe.sv
// Two-stage post-add normaliser: stage 1 captures the beat with its leading-zero count,
// stage 2 applies the shift and exponent adjust. Define NORM_STICKY_EN to keep a sticky LSB on right shifts.
module normalize_shifter_pipe #(
  parameter int MANT_W = 27,
  parameter int EXP_W  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [MANT_W-1:0]            in_mant,
  input  logic                         in_ovf,
  input  logic [EXP_W-1:0]             in_exp,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [MANT_W-1:0]            out_mant,
  output logic [EXP_W-1:0]             out_exp,
  output logic [1:0]                   out_shift_dir,
  output logic [$clog2(MANT_W):0]      out_shift_amt,
  output logic                         out_zero,
  output logic                         out_underflow,
  output logic                         out_overflow
);

  localparam int AMT_W = $clog2(MANT_W) + 1;
  localparam int CMP_W = (EXP_W > AMT_W) ? EXP_W : AMT_W;
  localparam logic [1:0] DIR_LEFT  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_NONE  = 2'b10;
  localparam logic [EXP_W-1:0] SAT_THR = {{(EXP_W-1){1'b1}}, 1'b0};

  function automatic logic [AMT_W-1:0] count_lz(input logic [MANT_W-1:0] m);
    logic [AMT_W-1:0] n;
    logic             found;
    n     = '0;
    found = 1'b0;
    for (int i = MANT_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (m[i]) found = 1'b1;
        else      n = n + AMT_W'(1);
      end
    end
    return n;
  endfunction

  logic              s1_valid;
  logic [MANT_W-1:0] s1_mant;
  logic              s1_ovf;
  logic              s1_sat;
  logic [EXP_W-1:0]  s1_exp;
  logic [AMT_W-1:0]  s1_lz;
  logic              s2_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mant  <= '0;
      s1_ovf   <= 1'b0;
      s1_sat   <= 1'b0;
      s1_exp   <= '0;
      s1_lz    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mant <= in_mant;
        s1_ovf  <= in_ovf;
        s1_sat  <= in_ovf && (in_exp >= SAT_THR);
        s1_exp  <= in_exp;
        s1_lz   <= count_lz(in_mant);
      end
    end
  end

  logic [CMP_W-1:0]  lz_c, exp_c, shl;
  logic [MANT_W-1:0] nxt_mant;
  logic [EXP_W-1:0]  nxt_exp;
  logic [1:0]        nxt_dir;
  logic [AMT_W-1:0]  nxt_amt;
  logic              nxt_zero, nxt_unf, nxt_ovf;

  always_comb begin
    lz_c     = CMP_W'(s1_lz);
    exp_c    = CMP_W'(s1_exp);
    shl      = (lz_c < exp_c) ? lz_c : exp_c;
    nxt_mant = s1_mant;
    nxt_exp  = s1_exp;
    nxt_dir  = DIR_NONE;
    nxt_amt  = '0;
    nxt_zero = 1'b0;
    nxt_unf  = 1'b0;
    nxt_ovf  = 1'b0;
    if (s1_ovf) begin
      nxt_mant = s1_mant >> 1;
`ifdef NORM_STICKY_EN
      nxt_mant[0] = s1_mant[1] | s1_mant[0];
`endif
      nxt_dir = DIR_RIGHT;
      nxt_amt = AMT_W'(1);
      if (s1_sat) begin
        nxt_exp = '1;
        nxt_ovf = 1'b1;
      end else begin
        nxt_exp = s1_exp + EXP_W'(1);
      end
    end else if (s1_mant[MANT_W-1]) begin
      nxt_mant = s1_mant;
    end else if (s1_mant == '0) begin
      nxt_mant = '0;
      nxt_exp  = '0;
      nxt_zero = 1'b1;
    end else begin
      // Shift is capped by the exponent so it bottoms out at zero instead of wrapping.
      nxt_mant = s1_mant << shl;
      nxt_exp  = s1_exp - EXP_W'(shl);
      nxt_dir  = DIR_LEFT;
      nxt_amt  = AMT_W'(shl);
      nxt_unf  = lz_c > exp_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_mant      <= '0;
      out_exp       <= '0;
      out_shift_dir <= DIR_NONE;
      out_shift_amt <= '0;
      out_zero      <= 1'b0;
      out_underflow <= 1'b0;
      out_overflow  <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_mant      <= nxt_mant;
        out_exp       <= nxt_exp;
        out_shift_dir <= nxt_dir;
        out_shift_amt <= nxt_amt;
        out_zero      <= nxt_zero;
        out_underflow <= nxt_unf;
        out_overflow  <= nxt_ovf;
      end
    end
  end

endmodule

// File: tb/tb_normalize_shifter_pipe.sv
// Scoreboard bench for normalize_shifter_pipe (MANT_W=27, EXP_W=8); honours NORM_STICKY_EN.
module tb_normalize_shifter_pipe;

  typedef struct packed {
    logic [26:0] mant;
    logic [7:0]  exp;
    logic [1:0]  dir;
    logic [5:0]  amt;
    logic        zero;
    logic        unf;
    logic        ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [26:0] in_mant = '0;
  logic        in_ovf = 1'b0;
  logic [7:0]  in_exp = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [26:0] out_mant;
  logic [7:0]  out_exp;
  logic [1:0]  out_shift_dir;
  logic [5:0]  out_shift_amt;
  logic        out_zero, out_underflow, out_overflow;

  int   n_cmp = 0;
  int   n_err = 0;
  res_t sb[$];
  logic use_fixed = 1'b0;
  res_t fixed_res = '0;
  bit   rand_done;

  normalize_shifter_pipe #(.MANT_W(27), .EXP_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_ovf(in_ovf), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp),
    .out_shift_dir(out_shift_dir), .out_shift_amt(out_shift_amt),
    .out_zero(out_zero), .out_underflow(out_underflow), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  // Reference: normalise by plain arithmetic on the mantissa value.
  function automatic res_t model(input logic [26:0] m, input logic o, input logic [7:0] e);
    res_t    r;
    longint  v;
    int      lz, s, ex;
    r     = '0;
    r.dir = 2'b10;
    if (o) begin
      r.mant = 27'(m / 2);
`ifdef NORM_STICKY_EN
      if (m % 2 == 1) r.mant = r.mant | 27'd1;
`endif
      r.dir = 2'b01;
      r.amt = 6'd1;
      ex = int'(e) + 1;
      if (ex >= 255) begin
        r.exp = 8'd255;
        r.ovf = 1'b1;
      end else begin
        r.exp = 8'(ex);
      end
    end else if (m == 0) begin
      r.zero = 1'b1;
    end else if (m >= 27'h4000000) begin
      r.mant = m;
      r.exp  = e;
    end else begin
      v  = longint'(m);
      lz = 0;
      while (v < 64'h4000000) begin
        v  = v * 2;
        lz = lz + 1;
      end
      s      = (lz < int'(e)) ? lz : int'(e);
      r.mant = 27'(longint'(m) * (longint'(1) << s));
      r.exp  = 8'(int'(e) - s);
      r.dir  = 2'b00;
      r.amt  = 6'(s);
      r.unf  = lz > int'(e);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic res_t dut_res();
    return {out_mant, out_exp, out_shift_dir, out_shift_amt, out_zero, out_underflow, out_overflow};
  endfunction

  task automatic monitor();
    res_t held_val, e;
    logic held;
    held = 1'b0;
    held_val = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        held = 1'b0;
      end else begin
        if (held && out_valid) chk("stall_stable", 64'(dut_res()), 64'(held_val));
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_beat", 64'(out_valid), 64'(0));
          end else begin
            e = sb.pop_front();
            chk("beat", 64'(dut_res()), 64'(e));
          end
        end
        held     = out_valid && !out_ready;
        held_val = dut_res();
        if (in_valid && in_ready)
          sb.push_back(use_fixed ? fixed_res : model(in_mant, in_ovf, in_exp));
      end
    end
  endtask

  task automatic send(input logic [26:0] m, input logic o, input logic [7:0] e,
                      input logic fx_en, input res_t fx);
    int n;
    in_valid  = 1'b1;
    in_mant   = m;
    in_ovf    = o;
    in_exp    = e;
    use_fixed = fx_en;
    fixed_res = fx;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) chk("send_timeout", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    use_fixed = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", 64'(sb.size()), 64'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  res_t fx;
  logic [26:0] sticky_m;

  initial begin
    fork monitor(); join_none
    #1 rst_n = 1'b0;
    #11;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_outputs", 64'(dut_res()), 64'({27'd0, 8'd0, 2'b10, 6'd0, 3'b000}));
    rst_n = 1'b1;  // t=12, between edges
    @(negedge clk);
    chk("ready_after_rst", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;

`ifdef NORM_STICKY_EN
    sticky_m = 27'h3000001;
`else
    sticky_m = 27'h3000000;
`endif
    // Directed corner cases, back to back, with spec-level expected values.
    send(27'h4000000, 1'b0, 8'd100, 1'b1, {27'h4000000, 8'd100, 2'b10, 6'd0, 3'b000});
    send(27'h6000001, 1'b1, 8'd100, 1'b1, {sticky_m, 8'd101, 2'b01, 6'd1, 3'b000});
    send(27'h6000001, 1'b1, 8'd254, 1'b1, {sticky_m, 8'd255, 2'b01, 6'd1, 3'b001});
    send(27'h6000001, 1'b1, 8'd255, 1'b1, {sticky_m, 8'd255, 2'b01, 6'd1, 3'b001});
    send(27'h0000100, 1'b0, 8'd100, 1'b1, {27'h4000000, 8'd82, 2'b00, 6'd18, 3'b000});
    send(27'h0000100, 1'b0, 8'd10,  1'b1, {27'h0040000, 8'd0, 2'b00, 6'd10, 3'b010});
    send(27'h0000100, 1'b0, 8'd18,  1'b1, {27'h4000000, 8'd0, 2'b00, 6'd18, 3'b000});
    send(27'h0000000, 1'b0, 8'd57,  1'b1, {27'h0000000, 8'd0, 2'b10, 6'd0, 3'b100});
    send(27'h0000001, 1'b0, 8'd200, 1'b1, {27'h4000000, 8'd174, 2'b00, 6'd26, 3'b000});
    drain();

    // Back-pressure: two beats fill the pipe, the third must stall.
    out_ready = 1'b0;
    fx = '0;
    send(27'h0000003, 1'b0, 8'd50, 1'b0, fx);
    send(27'h5000000, 1'b1, 8'd20, 1'b0, fx);
    fork
      begin
        send(27'h0001234, 1'b0, 8'd5, 1'b0, fx);
        send(27'h4abcdef, 1'b0, 8'd77, 1'b0, fx);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 64'(in_ready), 64'(0));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (4) begin
          @(negedge clk);
          chk("burst_out_valid", 64'(out_valid), 64'(1));
        end
      end
    join
    drain();

    // Reset with two beats in flight.
    send(27'h0000f00, 1'b0, 8'd30, 1'b0, fx);
    send(27'h7ffffff, 1'b1, 8'd30, 1'b0, fx);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_outputs", 64'(dut_res()), 64'({27'd0, 8'd0, 2'b10, 6'd0, 3'b000}));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_midrst", 64'(in_ready), 64'(1));
    repeat (6) begin
      @(negedge clk);
      chk("no_stale_beat", 64'(out_valid), 64'(0));
    end
    @(posedge clk);
    #1;

    // Random traffic with random back-pressure.
    rand_done = 1'b0;
    fork
      begin
        logic [26:0] m;
        logic [7:0]  e;
        int          sel;
        for (int i = 0; i < 400; i++) begin
          m   = 27'($urandom) >> $urandom_range(0, 27);
          sel = $urandom_range(0, 9);
          if (sel == 0)      e = 8'($urandom_range(0, 3));
          else if (sel == 1) e = 8'($urandom_range(252, 255));
          else               e = 8'($urandom);
          send(m, ($urandom_range(0, 3) == 0), e, 1'b0, fx);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
